// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm snooze controller.
package alarm_pkg;

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned CNT_W   = 3;

  localparam int unsigned SNOOZE_SEC_DEF       = 300;
  localparam int unsigned RING_TIMEOUT_SEC_DEF = 60;
  localparam int unsigned MAX_SNOOZE_DEF       = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRing,
    StSnooze,
    StWaitClear
  } alarm_state_e;

endpackage

// File: rtl/alarm_tick_timer.sv
// Loadable seconds countdown shared by the ring and snooze phases.
module alarm_tick_timer
  import alarm_pkg::*;
#(
  parameter int unsigned Width = TIMER_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             tick_i,
  output logic [Width-1:0] value_o,
  output logic             is_one_o
);

  logic [Width-1:0] value_q, value_d;

  // Load wins over decrement; the count never drops below 1 on its own.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (tick_i && (value_q > Width'(1))) begin
      value_d = value_q - Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign is_one_o = (value_q == Width'(1));

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm event controller: ring, snooze, unattended timeout and wait-for-clear.
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC       = SNOOZE_SEC_DEF,
  parameter int unsigned RING_TIMEOUT_SEC = RING_TIMEOUT_SEC_DEF,
  parameter int unsigned MAX_SNOOZE       = MAX_SNOOZE_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alarm_ringing,
  input  logic               sec_tick,
  input  logic               snooze_btn,
  input  logic               stop_btn,
  output logic               buzzer,
  output logic               ringing,
  output logic               snoozing,
  output logic [CNT_W-1:0]   snooze_count,
  output logic [TIMER_W-1:0] remaining_sec,
  output logic               timed_out
);

  alarm_state_e       state_q, state_d;
  logic               ring_q, ring_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               buzzer_q, buzzer_d;
  logic               timed_out_q, timed_out_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_is_one;
  logic               start;

  // A rising level on alarm_ringing starts an event; ring_q resets low on purpose.
  assign start = alarm_ringing && !ring_q;

  alarm_tick_timer #(
    .Width(TIMER_W)
  ) u_timer (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .tick_i    (tmr_dec),
    .value_o   (tmr_value),
    .is_one_o  (tmr_is_one)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers alongside the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ring_q      <= 1'b0;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      buzzer_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      ring_q      <= ring_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      buzzer_q    <= buzzer_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Next-state and timer control; priority is stop > snooze > tick.
  always_comb begin
    state_d      = state_q;
    ring_d       = alarm_ringing;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    timed_out_d  = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    // Buzzer lags the state/phase it reflects by one cycle.
    buzzer_d     = (state_q == StRing) && phase_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRing;
          tmr_load     = 1'b1;
          tmr_load_val = TIMER_W'(RING_TIMEOUT_SEC);
          phase_d      = 1'b1;
        end
      end
      StRing: begin
        if (stop_btn) begin
          state_d  = StWaitClear;
          tmr_load = 1'b1;
          phase_d  = 1'b0;
        end else if (snooze_btn && (cnt_q < CNT_W'(MAX_SNOOZE))) begin
          state_d      = StSnooze;
          tmr_load     = 1'b1;
          tmr_load_val = TIMER_W'(SNOOZE_SEC);
          cnt_d        = cnt_q + CNT_W'(1);
        end else if (sec_tick) begin
          // A snooze press at the limit is treated as no press at all.
          if (tmr_is_one) begin
            state_d     = StWaitClear;
            tmr_load    = 1'b1;
            phase_d     = 1'b0;
            timed_out_d = 1'b1;
          end else begin
            tmr_dec = 1'b1;
            phase_d = ~phase_q;
          end
        end
      end
      StSnooze: begin
        if (stop_btn) begin
          state_d  = StWaitClear;
          tmr_load = 1'b1;
          phase_d  = 1'b0;
        end else if (sec_tick) begin
          if (tmr_is_one) begin
            state_d      = StRing;
            tmr_load     = 1'b1;
            tmr_load_val = TIMER_W'(RING_TIMEOUT_SEC);
            phase_d      = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end
      StWaitClear: begin
        // Hold off until the match minute ends so the same alarm cannot re-fire.
        if (!alarm_ringing) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs.
  always_comb begin
    ringing       = (state_q == StRing);
    snoozing      = (state_q == StSnooze);
    buzzer        = buzzer_q;
    timed_out     = timed_out_q;
    snooze_count  = cnt_q;
    remaining_sec = tmr_value;
  end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Self-checking bench for alarm_snooze_ctrl (SNOOZE_SEC=3, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2).
module tb_alarm_snooze_ctrl;

  localparam int SnzSec  = 3;
  localparam int RingSec = 4;
  localparam int MaxSnz  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alarm_ringing = 1'b0;
  logic        sec_tick = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic        buzzer, ringing, snoozing, timed_out;
  logic [2:0]  snooze_count;
  logic [15:0] remaining_sec;

  int total = 0;
  int bad = 0;

  alarm_snooze_ctrl #(
    .SNOOZE_SEC      (SnzSec),
    .RING_TIMEOUT_SEC(RingSec),
    .MAX_SNOOZE      (MaxSnz)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .alarm_ringing(alarm_ringing),
    .sec_tick     (sec_tick),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_count (snooze_count),
    .remaining_sec(remaining_sec),
    .timed_out    (timed_out)
  );

  always #5 clock = ~clock;

  // Behavioural model: mode 0 idle, 1 ring, 2 snooze, 3 waiting for alarm to clear.
  int m_mode, m_timer, m_count;
  bit m_phase, m_prev_ar, m_buz, m_to;

  function automatic void model_reset();
    m_mode = 0; m_timer = 0; m_count = 0;
    m_phase = 0; m_prev_ar = 0; m_buz = 0; m_to = 0;
  endfunction

  function automatic void model_step(input bit ar, input bit tk, input bit sz, input bit sp);
    bit rising;
    bit snooze_ok;
    rising    = ar && !m_prev_ar;
    snooze_ok = sz && (m_count < MaxSnz);
    m_buz     = (m_mode == 1) && m_phase;
    m_to      = 0;
    if (m_mode == 0) begin
      if (rising) begin m_mode = 1; m_timer = RingSec; m_phase = 1; end
    end else if (m_mode == 1) begin
      if (sp) begin m_mode = 3; m_timer = 0; end
      else if (snooze_ok) begin m_mode = 2; m_timer = SnzSec; m_count++; end
      else if (tk && m_timer == 1) begin m_mode = 3; m_timer = 0; m_to = 1; end
      else if (tk) begin m_timer--; m_phase = !m_phase; end
    end else if (m_mode == 2) begin
      if (sp) begin m_mode = 3; m_timer = 0; end
      else if (tk && m_timer == 1) begin m_mode = 1; m_timer = RingSec; m_phase = 1; end
      else if (tk) m_timer--;
    end else begin
      if (!ar) begin m_mode = 0; m_count = 0; end
    end
    m_prev_ar = ar;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ringing"}, int'(ringing), int'(m_mode == 1));
    chk({tag, ".snoozing"}, int'(snoozing), int'(m_mode == 2));
    chk({tag, ".count"}, int'(snooze_count), m_count);
    chk({tag, ".remaining"}, int'(remaining_sec), m_timer);
    chk({tag, ".timed_out"}, int'(timed_out), int'(m_to));
    chk({tag, ".buzzer"}, int'(buzzer), int'(m_buz));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ringing"}, int'(ringing), 0);
    chk({tag, ".snoozing"}, int'(snoozing), 0);
    chk({tag, ".count"}, int'(snooze_count), 0);
    chk({tag, ".remaining"}, int'(remaining_sec), 0);
    chk({tag, ".timed_out"}, int'(timed_out), 0);
    chk({tag, ".buzzer"}, int'(buzzer), 0);
  endtask

  // Apply inputs for one cycle; returns 1ns after the edge with pulses cleared.
  task automatic drive(input bit ar, input bit tk, input bit sz, input bit sp);
    alarm_ringing = ar; sec_tick = tk; snooze_btn = sz; stop_btn = sp;
    @(posedge clock);
    model_step(ar, tk, sz, sp);
    #1;
    sec_tick = 0; snooze_btn = 0; stop_btn = 0;
  endtask

  typedef struct {
    bit ar, tk, sz, sp;
    bit e_ring, e_snz;
    int e_cnt, e_rem;
    bit e_to, e_buz;
  } vec_t;

  vec_t vecs[$];

  initial begin
    model_reset();
    // ar tk sz sp | ring snz cnt rem to buz
    vecs.push_back('{0,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,0,0,4,0,0});
    vecs.push_back('{1,0,0,0, 1,0,0,4,0,1});
    vecs.push_back('{1,1,0,0, 1,0,0,3,0,1});
    vecs.push_back('{1,0,0,0, 1,0,0,3,0,0});
    vecs.push_back('{1,1,0,0, 1,0,0,2,0,0});
    vecs.push_back('{1,1,0,0, 1,0,0,1,0,1});
    vecs.push_back('{1,1,0,0, 0,0,0,0,1,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,0,0,4,0,0});
    vecs.push_back('{1,0,1,0, 0,1,1,3,0,1});
    vecs.push_back('{0,1,0,0, 0,1,1,2,0,0});
    vecs.push_back('{0,1,0,0, 0,1,1,1,0,0});
    vecs.push_back('{1,1,0,0, 1,0,1,4,0,0});
    vecs.push_back('{1,0,0,0, 1,0,1,4,0,1});
    vecs.push_back('{1,0,1,0, 0,1,2,3,0,1});
    vecs.push_back('{1,1,0,0, 0,1,2,2,0,0});
    vecs.push_back('{1,1,0,0, 0,1,2,1,0,0});
    vecs.push_back('{1,1,0,0, 1,0,2,4,0,0});
    vecs.push_back('{1,0,1,0, 1,0,2,4,0,1});
    vecs.push_back('{1,0,1,1, 0,0,2,0,0,1});

    // Reset state, held with alarm high to show it is ignored during reset.
    alarm_ringing = 1;
    #3;
    check_zero("reset");
    @(posedge clock);
    #1;
    alarm_ringing = 0;
    reset = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ar, vecs[i].tk, vecs[i].sz, vecs[i].sp);
      chk($sformatf("vec%0d.ringing", i), int'(ringing), int'(vecs[i].e_ring));
      chk($sformatf("vec%0d.snoozing", i), int'(snoozing), int'(vecs[i].e_snz));
      chk($sformatf("vec%0d.count", i), int'(snooze_count), vecs[i].e_cnt);
      chk($sformatf("vec%0d.remaining", i), int'(remaining_sec), vecs[i].e_rem);
      chk($sformatf("vec%0d.timed_out", i), int'(timed_out), int'(vecs[i].e_to));
      chk($sformatf("vec%0d.buzzer", i), int'(buzzer), int'(vecs[i].e_buz));
    end

    // Alarm held high after stop: no re-ring for the rest of the match minute.
    for (int i = 0; i < 10; i++) begin
      drive(1, i % 2, 0, 0);
      chk("hold.ringing", int'(ringing), 0);
      chk("hold.count", int'(snooze_count), 2);
    end
    drive(0, 0, 0, 0);
    chk("clear.count", int'(snooze_count), 0);
    chk("clear.snoozing", int'(snoozing), 0);

    // Snooze pressed on the same cycle as the final ring second.
    drive(1, 0, 0, 0);
    chk("edge.ringing", int'(ringing), 1);
    for (int i = 0; i < RingSec - 1; i++) drive(1, 1, 0, 0);
    chk("edge.remaining", int'(remaining_sec), 1);
    drive(1, 1, 1, 0);
    chk("edge.snoozing", int'(snoozing), 1);
    chk("edge.timed_out", int'(timed_out), 0);
    chk("edge.remaining2", int'(remaining_sec), SnzSec);
    check_model("edge");

    // Asynchronous reset mid-snooze with the alarm still high.
    alarm_ringing = 1;
    #2;
    reset = 1;
    #1;
    check_zero("midrst");
    @(posedge clock);
    #1;
    check_zero("midrst_hold");
    reset = 0;
    model_reset();
    drive(1, 0, 0, 0);
    chk("rst_release.ringing", int'(ringing), 1);
    chk("rst_release.remaining", int'(remaining_sec), RingSec);
    check_model("rst_release");

    // Randomized run against the model, with occasional resets.
    begin
      bit ar;
      ar = 1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 15) == 0) ar = !ar;
        if ($urandom_range(0, 599) == 0) begin
          reset = 1;
          #2;
          check_zero("rnd_rst");
          @(posedge clock);
          #1;
          reset = 0;
          model_reset();
        end
        drive(ar, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 24) == 0);
        check_model("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_snooze_ctrl.md
ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

Interface
REQ-001 Parameter SNOOZE_SEC, default 300, snooze length in sec_tick pulses (1..65535).
REQ-002 Parameter RING_TIMEOUT_SEC, default 60, unattended ring length in sec_tick pulses (1..65535).
REQ-003 Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event (0..7).
REQ-004 clock  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alarm_ringing  input  1  level from alarm_clock, high while time matches alarm time.
REQ-007 sec_tick  input  1  one-cycle pulse, once per second.
REQ-008 snooze_btn  input  1  debounced one-cycle pulse.
REQ-009 stop_btn  input  1  debounced one-cycle pulse.
REQ-010 buzzer  output  1  beep drive, registered.
REQ-011 ringing  output  1  high in state RING.
REQ-012 snoozing  output  1  high in state SNOOZE.
REQ-013 snooze_count  output  3  snoozes taken in current alarm event.
REQ-014 remaining_sec  output  16  current timer value (ring or snooze countdown), 0 in IDLE/WAIT_CLEAR.
REQ-015 timed_out  output  1  one-cycle pulse when ring times out unattended.

Function
REQ-016 FSM states SHALL be IDLE, RING, SNOOZE, WAIT_CLEAR; encoding from package enum.
REQ-017 Start event = alarm_ringing high while registered copy ring_q low; ring_q resets to 0, so a high level after reset counts as a start.
REQ-018 IDLE: start event -> RING next cycle; timer <= RING_TIMEOUT_SEC, beep_phase <= 1; all other inputs ignored.
REQ-019 RING: stop_btn -> WAIT_CLEAR; else snooze_btn with snooze_count < MAX_SNOOZE -> SNOOZE, timer <= SNOOZE_SEC, snooze_count +1; snooze_btn at limit SHALL be ignored.
REQ-020 RING, no button, sec_tick: timer==1 -> WAIT_CLEAR and timed_out pulse same edge; else timer -1 and beep_phase toggles.
REQ-021 SNOOZE: stop_btn -> WAIT_CLEAR; snooze_btn ignored; sec_tick with timer==1 -> RING, timer <= RING_TIMEOUT_SEC, beep_phase <= 1; else sec_tick decrements timer.
REQ-022 WAIT_CLEAR: alarm_ringing low -> IDLE with snooze_count <= 0; stays while alarm_ringing high (no re-trigger within same match minute).
REQ-023 Priority in one cycle: stop_btn > snooze_btn > sec_tick; a button cycle coinciding with sec_tick SHALL not decrement.
REQ-024 buzzer = registered (state==RING && beep_phase); latency one cycle after state/phase update, i.e. buzzer high the cycle RING is entered's next-edge output.
REQ-025 Timer 16-bit unsigned, never decrements below 1 in RING/SNOOZE; cleared to 0 on entering WAIT_CLEAR.
REQ-026 alarm_ringing falling during RING or SNOOZE SHALL not abort; ring/snooze continue until button or timeout.

Reset
REQ-027 reset high: state IDLE, ring_q 0, timer 0, beep_phase 0, snooze_count 0, buzzer/ringing/snoozing/timed_out 0, remaining_sec 0, immediately and independent of clock.
REQ-028 reset asserted mid-RING or mid-SNOOZE SHALL abandon the event fully; release with alarm_ringing high restarts RING per REQ-017.

Structure
REQ-029 Package alarm_pkg SHALL hold the state enum, TIMER_W=16, CNT_W=3, and default constants for SNOOZE_SEC, RING_TIMEOUT_SEC, MAX_SNOOZE.
REQ-030 One sub-module alarm_tick_timer (load value, load strobe, sec_tick decrement, is_one flag) SHALL implement the shared countdown.

Verification (SNOOZE_SEC=3, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2)
REQ-031 alarm_ringing 0->1 -> ringing=1 next cycle, remaining_sec=4, buzzer toggles each sec_tick; 4 ticks -> timed_out pulse, state WAIT_CLEAR; drop alarm_ringing -> IDLE.
REQ-032 Ring, snooze_btn -> snoozing=1, snooze_count=1, remaining_sec=3; 3 ticks -> ringing=1, remaining_sec=4.
REQ-033 Snooze twice, third snooze_btn in RING -> ignored, ringing stays 1, snooze_count=2.
REQ-034 stop_btn and snooze_btn same cycle in RING -> WAIT_CLEAR, snooze_count unchanged; alarm_ringing held high 10 cycles -> no re-ring; low -> IDLE, snooze_count=0.
REQ-035 snooze_btn coincident with sec_tick in RING with remaining_sec=1 -> SNOOZE, no timed_out.
REQ-036 reset pulse mid-SNOOZE with alarm_ringing high -> all outputs 0 during reset, ringing=1 one cycle after release.
